fetch_unit: RTL and testbench



---
 rtl/fetch_if.sv | 32 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: control/fetch bus between the instruction-sequencing side and
// fetch_unit.
//   master : drives start, inst, pc_sel, change (and step_mode/step when the
//            FETCH_SINGLE_STEP_EN option is compiled in); observes pc,
//            exec_en, running, halted, retired.
//   slave  : fetch_unit side, the mirror of master.
// PC_WIDTH must match the PC_WIDTH of the fetch_unit the interface is bound to.
interface fetch_if #(parameter int PC_WIDTH = 8);
  logic                start;
  logic [15:0]         inst;
  logic                pc_sel;
  logic                change;
  logic [PC_WIDTH-1:0] pc;
  logic                exec_en;
  logic                running;
  logic                halted;
  logic [15:0]         retired;
`ifdef FETCH_SINGLE_STEP_EN
  logic                step_mode;
  logic                step;

  modport master (output start, inst, pc_sel, change, step_mode, step,
                  input  pc, exec_en, running, halted, retired);
  modport slave  (input  start, inst, pc_sel, change, step_mode, step,
                  output pc, exec_en, running, halted, retired);
`else
  modport master (output start, inst, pc_sel, change,
                  input  pc, exec_en, running, halted, retired);
  modport slave  (input  start, inst, pc_sel, change,
                  output pc, exec_en, running, halted, retired);
`endif
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch sequencer for the 16-bit single-cycle core.
// Holds the PC (instruction-memory address), computes the next PC from the
// control unit's pc_sel/change and the 9-bit branch offset in inst, runs an
// IDLE/RUN/HALTED sequencer, and counts retired instructions (saturating).
//
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_if.slave: start, inst, pc_sel, change in;
//          pc, exec_en, running, halted, retired out
//
// Option macro FETCH_SINGLE_STEP_EN: adds bus.step_mode/bus.step. With
// step_mode=1 a RUN cycle commits only when step=1.
module fetch_unit #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  // Adder width: wide enough for both the PC and the 9-bit offset, so the
  // sign extension is correct even for very narrow PCs.
  localparam int AW = (PC_WIDTH > 9) ? PC_WIDTH : 9;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                running_q;
  logic                halted_q;
  logic [15:0]         retired_q;
  logic                commit;

  logic signed [8:0]   offs;
  logic [AW-1:0]       pc_ext;
  logic [AW-1:0]       seq_sum;
  logic [AW-1:0]       tgt_sum;
  logic [PC_WIDTH-1:0] pc_next;

  // Commit qualifier is combinational from registered state so downstream
  // write enables see it in the same cycle as the instruction.
`ifdef FETCH_SINGLE_STEP_EN
  assign commit = running_q & (~bus.step_mode | bus.step);
`else
  assign commit = running_q;
`endif

  // Modulo 2^PC_WIDTH arithmetic falls out of truncating the sums.
  assign offs    = bus.inst[8:0];
  assign pc_ext  = AW'(pc_q);
  assign seq_sum = pc_ext + AW'(1);
  assign tgt_sum = seq_sum + AW'(offs);
  assign pc_next = bus.pc_sel ? tgt_sum[PC_WIDTH-1:0] : seq_sum[PC_WIDTH-1:0];

  // Opcode bits and adder carry-outs are intentionally not used here.
  logic unused_bits;
  assign unused_bits = ^{bus.inst[15:9], seq_sum, tgt_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= PC_WIDTH'(RESET_PC);
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          pc_q <= PC_WIDTH'(RESET_PC);
          if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // start is ignored here; only a committed HALT leaves RUN.
          if (commit) begin
            if (bus.change) begin
              pc_q <= pc_next;
              if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
            end else begin
              // HALT: PC stays on the HALT address, not counted.
              state     <= HALTED;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
            pc_q      <= PC_WIDTH'(RESET_PC);
            retired_q <= 16'h0000;
          end
        end
        default: begin
          state     <= IDLE;
          pc_q      <= PC_WIDTH'(RESET_PC);
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc      = pc_q;
  assign bus.exec_en = commit;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, straight-line program with HALT,
// restart from HALTED, branches, PC wrap, reset during RUN, and (when the
// option is compiled in) single-step.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  localparam logic [15:0] ADD = 16'h1000;

  fetch_if #(.PC_WIDTH(8)) bus ();

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and checks happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n plain sequential commits.
  task automatic run_n(input int n);
    bus.inst = ADD; bus.pc_sel = 1'b0; bus.change = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset_start();
    rst = 1'b1; bus.start = 1'b0; tick();
    rst = 1'b0; bus.start = 1'b1; tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.inst = ADD; bus.pc_sel = 1'b0; bus.change = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    vectors++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", bus.pc); end
    vectors++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", bus.running); end
    vectors++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    vectors++; if (bus.exec_en !== 1'b0) begin errors++; $display("FAIL reset_exec_en got %b want 0", bus.exec_en); end
    vectors++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL reset_retired got %h want 0000", bus.retired); end
    // IDLE holds without start
    tick();
    vectors++; if (bus.running !== 1'b0 || bus.pc !== 8'h00) begin errors++; $display("FAIL idle_hold got run=%b pc=%h want 0/00", bus.running, bus.pc); end
  endtask

  task automatic test_program();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    vectors++; if (bus.running !== 1'b1 || bus.exec_en !== 1'b1) begin errors++; $display("FAIL start_run got run=%b en=%b want 1/1", bus.running, bus.exec_en); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.pc !== 8'(i)) begin errors++; $display("FAIL prog_pc%0d got %h want %h", i, bus.pc, 8'(i)); end
      bus.inst = ADD; bus.pc_sel = 1'b0; bus.change = (i < 3);
      tick();
    end
    bus.change = 1'b1;
    vectors++; if (bus.halted !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL halt_state got h=%b r=%b want 1/0", bus.halted, bus.running); end
    vectors++; if (bus.retired !== 16'd3) begin errors++; $display("FAIL halt_retired got %0d want 3", bus.retired); end
    vectors++; if (bus.exec_en !== 1'b0) begin errors++; $display("FAIL halt_exec_en got %b want 0", bus.exec_en); end
    tick(); tick();
    vectors++; if (bus.pc !== 8'h03 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_frozen got pc=%h h=%b want 03/1", bus.pc, bus.halted); end
  endtask

  task automatic test_restart();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    vectors++; if (bus.running !== 1'b1 || bus.halted !== 1'b0) begin errors++; $display("FAIL restart_state got r=%b h=%b want 1/0", bus.running, bus.halted); end
    vectors++; if (bus.pc !== 8'h00 || bus.retired !== 16'd0) begin errors++; $display("FAIL restart_clear got pc=%h ret=%0d want 00/0", bus.pc, bus.retired); end
    // start while RUN is ignored: normal sequential advance
    bus.start = 1'b1; run_n(1); bus.start = 1'b0;
    vectors++; if (bus.pc !== 8'h01 || bus.retired !== 16'd1) begin errors++; $display("FAIL start_in_run got pc=%h ret=%0d want 01/1", bus.pc, bus.retired); end
  endtask

  task automatic test_branch();
    do_reset_start();
    run_n(5);
    vectors++; if (bus.pc !== 8'h05) begin errors++; $display("FAIL br_setup got %h want 05", bus.pc); end
    bus.inst = 16'h01FC; bus.pc_sel = 1'b1; bus.change = 1'b1; tick();
    vectors++; if (bus.pc !== 8'h02) begin errors++; $display("FAIL br_taken got %h want 02", bus.pc); end
    run_n(3);
    bus.inst = 16'h01FC; bus.pc_sel = 1'b0; bus.change = 1'b1; tick();
    vectors++; if (bus.pc !== 8'h06) begin errors++; $display("FAIL br_not_taken got %h want 06", bus.pc); end
    vectors++; if (bus.retired !== 16'd10) begin errors++; $display("FAIL br_retired got %0d want 10", bus.retired); end
  endtask

  task automatic test_wrap();
    // 6 + 1 + 247 = 0xFE
    bus.inst = 16'h00F7; bus.pc_sel = 1'b1; bus.change = 1'b1; tick();
    vectors++; if (bus.pc !== 8'hFE) begin errors++; $display("FAIL wrap_setup got %h want fe", bus.pc); end
    bus.inst = 16'h0003; bus.pc_sel = 1'b1; tick();
    vectors++; if (bus.pc !== 8'h02) begin errors++; $display("FAIL wrap_fwd got %h want 02", bus.pc); end
    // 2 + 1 + 252 = 0xFF
    bus.inst = 16'h00FC; bus.pc_sel = 1'b1; tick();
    vectors++; if (bus.pc !== 8'hFF) begin errors++; $display("FAIL wrap_to_ff got %h want ff", bus.pc); end
    bus.pc_sel = 1'b0; tick();
    vectors++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL wrap_inc got %h want 00", bus.pc); end
    // 0 + 1 - 4 = -3
    bus.inst = 16'h01FC; bus.pc_sel = 1'b1; tick();
    vectors++; if (bus.pc !== 8'hFD) begin errors++; $display("FAIL wrap_neg got %h want fd", bus.pc); end
    bus.pc_sel = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset_start();
    run_n(7);
    vectors++; if (bus.pc !== 8'h07 || bus.retired !== 16'd7) begin errors++; $display("FAIL mid_setup got pc=%h ret=%0d want 07/7", bus.pc, bus.retired); end
    rst = 1'b1; bus.start = 1'b1; tick();
    rst = 1'b0; bus.start = 1'b0; #1;
    vectors++; if (bus.pc !== 8'h00 || bus.retired !== 16'd0) begin errors++; $display("FAIL mid_rst got pc=%h ret=%0d want 00/0", bus.pc, bus.retired); end
    vectors++; if (bus.running !== 1'b0 || bus.halted !== 1'b0 || bus.exec_en !== 1'b0) begin errors++; $display("FAIL mid_rst_state got r=%b h=%b e=%b want 0/0/0", bus.running, bus.halted, bus.exec_en); end
    tick();
    vectors++; if (bus.running !== 1'b0 || bus.pc !== 8'h00) begin errors++; $display("FAIL mid_rst_idle got r=%b pc=%h want 0/00", bus.running, bus.pc); end
  endtask

`ifdef FETCH_SINGLE_STEP_EN
  task automatic test_step();
    logic [4:0] pat;
    pat = 5'b01001;
    do_reset_start();
    bus.step_mode = 1'b1;
    bus.inst = ADD; bus.pc_sel = 1'b0; bus.change = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.step = pat[i]; #1;
      vectors++; if (bus.exec_en !== pat[i]) begin errors++; $display("FAIL step_en%0d got %b want %b", i, bus.exec_en, pat[i]); end
      tick();
    end
    vectors++; if (bus.pc !== 8'h02 || bus.retired !== 16'd2) begin errors++; $display("FAIL step_count got pc=%h ret=%0d want 02/2", bus.pc, bus.retired); end
    // HALT without step does not halt
    bus.change = 1'b0; bus.step = 1'b0; tick();
    vectors++; if (bus.halted !== 1'b0 || bus.running !== 1'b1) begin errors++; $display("FAIL step_halt_gate got h=%b r=%b want 0/1", bus.halted, bus.running); end
    bus.step = 1'b1; tick();
    vectors++; if (bus.halted !== 1'b1 || bus.pc !== 8'h02) begin errors++; $display("FAIL step_halt got h=%b pc=%h want 1/02", bus.halted, bus.pc); end
    bus.step_mode = 1'b0; bus.step = 1'b0; bus.change = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.inst = ADD; bus.pc_sel = 1'b0; bus.change = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
    bus.step_mode = 1'b0; bus.step = 1'b0;
`endif
    test_reset();
    test_program();
    test_restart();
    test_branch();
    test_wrap();
    test_rst_mid();
`ifdef FETCH_SINGLE_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout after 100000ns");
    $fatal(1, "timeout");
  end
endmodule
